// File: rtl/ulpi_reg_arbiter.sv
// ulpi_reg_arbiter: shares the ULPI register-access port between N_REQ
// requesters. It grants requesters round-robin and runs one register
// transaction at a time. An access that gets no reg_rdy within TIMEOUT
// cycles is aborted. Read data and the completion pulse go back to the
// requester that was granted.
module ulpi_reg_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_en,
    input  logic [N_REQ-1:0]   req_we,
    input  logic [8*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_din,
    output logic [N_REQ-1:0]   req_rdy,
    output logic [7:0]         req_dout,
    output logic               req_err,
    output logic               busy,
    output logic               reg_en,
    input  logic               reg_rdy,
    output logic               reg_we,
    output logic [7:0]         reg_addr,
    output logic [7:0]         reg_din,
    input  logic [7:0]         reg_dout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    g_q, g_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             reg_en_q, reg_en_d;
    logic             reg_we_q, reg_we_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic [7:0]       reg_din_q, reg_din_d;
    logic [N_REQ-1:0] req_rdy_q, req_rdy_d;
    logic [7:0]       req_dout_q, req_dout_d;
    logic             req_err_q, req_err_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [PW-1:0]    win;
    logic             sel_we;
    logic [7:0]       sel_addr;
    logic [7:0]       sel_din;

    // Round-robin search: the first active request from ptr upward, with wrap-around.
    always_comb begin
        int            sum;
        logic [PW-1:0] cand;
        found = 1'b0;
        win   = '0;
        sum   = 0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = PW'(sum);
            if (!found && req_en[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Pick the winner's access fields so they can be latched on grant.
    always_comb begin
        sel_we   = req_we[win];
        sel_addr = '0;
        sel_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PW'(i)) begin
                sel_addr = req_addr[8*i +: 8];
                sel_din  = req_din[8*i +: 8];
            end
        end
    end

    // Next-state logic for the FSM and all registered outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_d        = g_q;
        cnt_d      = cnt_q;
        reg_we_d   = reg_we_q;
        reg_addr_d = reg_addr_q;
        reg_din_d  = reg_din_q;
        req_dout_d = req_dout_q;
        req_err_d  = req_err_q;
        req_rdy_d  = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BUSY;
                    g_d        = win;
                    ptr_d      = (win == LAST_IDX) ? '0 : win + 1'b1;
                    reg_we_d   = sel_we;
                    reg_addr_d = sel_addr;
                    reg_din_d  = sel_din;
                    cnt_d      = '0;
                end
            end
            BUSY: begin
                // reg_rdy takes priority over a timeout that falls in the same cycle
                if (reg_rdy) begin
                    state_d         = RESP;
                    req_dout_d      = reg_dout;
                    req_err_d       = 1'b0;
                    req_rdy_d[g_q]  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = RESP;
                    req_dout_d      = '0;
                    req_err_d       = 1'b1;
                    req_rdy_d[g_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        reg_en_d = (state_d == BUSY);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            g_q        <= '0;
            cnt_q      <= '0;
            reg_en_q   <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_din_q  <= '0;
            req_rdy_q  <= '0;
            req_dout_q <= '0;
            req_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_q        <= g_d;
            cnt_q      <= cnt_d;
            reg_en_q   <= reg_en_d;
            reg_we_q   <= reg_we_d;
            reg_addr_q <= reg_addr_d;
            reg_din_q  <= reg_din_d;
            req_rdy_q  <= req_rdy_d;
            req_dout_q <= req_dout_d;
            req_err_q  <= req_err_d;
            busy_q     <= busy_d;
        end
    end

    assign reg_en   = reg_en_q;
    assign reg_we   = reg_we_q;
    assign reg_addr = reg_addr_q;
    assign reg_din  = reg_din_q;
    assign req_rdy  = req_rdy_q;
    assign req_dout = req_dout_q;
    assign req_err  = req_err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Directed testbench for ulpi_reg_arbiter (N_REQ=3, TIMEOUT=8).
module tb_ulpi_reg_arbiter;

    localparam int N_REQ   = 3;
    localparam int TIMEOUT = 8;

    logic         clk;
    logic         rst;
    logic [2:0]   req_en;
    logic [2:0]   req_we;
    logic [23:0]  req_addr;
    logic [23:0]  req_din;
    logic [2:0]   req_rdy;
    logic [7:0]   req_dout;
    logic         req_err;
    logic         busy;
    logic         reg_en;
    logic         reg_rdy;
    logic         reg_we;
    logic [7:0]   reg_addr;
    logic [7:0]   reg_din;
    logic [7:0]   reg_dout;

    int           n_tests;
    int           n_fail;
    logic [2:0]   rdy_seen;
    int           en_hi;

    ulpi_reg_arbiter #(
        .N_REQ  (N_REQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_en  (req_en),
        .req_we  (req_we),
        .req_addr(req_addr),
        .req_din (req_din),
        .req_rdy (req_rdy),
        .req_dout(req_dout),
        .req_err (req_err),
        .busy    (busy),
        .reg_en  (reg_en),
        .reg_rdy (reg_rdy),
        .reg_we  (reg_we),
        .reg_addr(reg_addr),
        .reg_din (reg_din),
        .reg_dout(reg_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and accumulate observations.
    task automatic step();
        @(negedge clk);
        rdy_seen = rdy_seen | req_rdy;
        if (reg_en) en_hi++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rdy_seen = '0;
        en_hi    = 0;
        rst      = 1'b0;
        req_en   = '0;
        req_we   = '0;
        req_addr = '0;
        req_din  = '0;
        reg_rdy  = 1'b0;
        reg_dout = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_reg_en",   32'(reg_en),   0);
        check("rst_busy",     32'(busy),     0);
        check("rst_req_rdy",  32'(req_rdy),  0);
        check("rst_req_dout", 32'(req_dout), 0);
        check("rst_req_err",  32'(req_err),  0);
        check("rst_reg_we",   32'(reg_we),   0);
        check("rst_reg_addr", 32'(reg_addr), 0);
        check("rst_reg_din",  32'(reg_din),  0);
        rst = 1'b1;
        step();
        check("idle_busy", 32'(busy), 0);

        // All three requesters held: grants rotate 0,1,2,0,1,2
        req_addr = 24'h32_21_10;
        req_en   = 3'b111;
        step();
        for (int t = 0; t < 6; t++) begin
            check("rr_reg_en",   32'(reg_en),   1);
            check("rr_reg_addr", 32'(reg_addr), 32'h10 + 32'h11 * (t % 3));
            reg_rdy  = 1'b1;
            reg_dout = 8'(8'hA0 + t);
            step();
            reg_rdy = 1'b0;
            check("rr_req_rdy",  32'(req_rdy),  32'(1) << (t % 3));
            check("rr_req_dout", 32'(req_dout), 32'hA0 + t);
            check("rr_gap1",     32'(reg_en),   0);
            if (t == 5) req_en = 3'b000;
            step();
            check("rr_gap2", 32'(reg_en), 0);
            step();
        end
        check("rr_end_busy", 32'(busy), 0);

        // Single read by requester 1, acknowledged on the third BUSY cycle
        req_we          = 3'b000;
        req_addr[15:8]  = 8'h0A;
        rdy_seen        = '0;
        en_hi           = 0;
        req_en          = 3'b010;
        step();
        check("rd_reg_addr", 32'(reg_addr), 32'h0A);
        check("rd_reg_we",   32'(reg_we),   0);
        check("rd_busy",     32'(busy),     1);
        step();
        step();
        reg_rdy  = 1'b1;
        reg_dout = 8'h5A;
        step();
        reg_rdy = 1'b0;
        check("rd_req_rdy",  32'(req_rdy),  32'b010);
        check("rd_req_dout", 32'(req_dout), 32'h5A);
        check("rd_req_err",  32'(req_err),  0);
        check("rd_resp_busy", 32'(busy),    1);
        req_en = 3'b000;
        step();
        step();
        check("rd_en_cycles", 32'(en_hi),    3);
        check("rd_rdy_bits",  32'(rdy_seen), 32'b010);
        check("rd_idle_busy", 32'(busy),     0);

        // Write by requester 0 with no reg_rdy: timeout after 8 cycles
        req_we         = 3'b001;
        req_addr[7:0]  = 8'h04;
        req_din[7:0]   = 8'h48;
        en_hi          = 0;
        req_en         = 3'b001;
        step();
        check("to_reg_we",   32'(reg_we),   1);
        check("to_reg_din",  32'(reg_din),  32'h48);
        check("to_reg_addr", 32'(reg_addr), 32'h04);
        repeat (8) step();
        check("to_en_cycles", 32'(en_hi),    8);
        check("to_req_rdy",   32'(req_rdy),  32'b001);
        check("to_req_err",   32'(req_err),  1);
        check("to_req_dout",  32'(req_dout), 0);
        check("to_reg_en",    32'(reg_en),   0);
        req_en = 3'b000;
        step();
        check("to_idle_busy", 32'(busy),    0);
        check("to_idle_rdy",  32'(req_rdy), 0);

        // reg_rdy on exactly the TIMEOUT-th BUSY cycle wins over the timeout
        req_we           = 3'b000;
        req_addr[23:16]  = 8'h77;
        en_hi            = 0;
        req_en           = 3'b100;
        step();
        repeat (7) step();
        reg_rdy  = 1'b1;
        reg_dout = 8'h33;
        step();
        reg_rdy = 1'b0;
        check("edge_en_cycles", 32'(en_hi),    8);
        check("edge_req_rdy",   32'(req_rdy),  32'b100);
        check("edge_req_err",   32'(req_err),  0);
        check("edge_req_dout",  32'(req_dout), 32'h33);
        req_en = 3'b000;
        step();

        // Stray reg_rdy pulses while idle are ignored
        reg_dout = 8'hFF;
        rdy_seen = '0;
        for (int i = 0; i < 3; i++) begin
            reg_rdy = 1'b1;
            step();
            reg_rdy = 1'b0;
            step();
        end
        check("stray_rdy",    32'(rdy_seen), 0);
        check("stray_dout",   32'(req_dout), 32'h33);
        check("stray_busy",   32'(busy),     0);
        check("stray_reg_en", 32'(reg_en),   0);

        // Asynchronous reset in the middle of a BUSY access
        req_en = 3'b010;
        step();
        step();
        check("ar_pre_busy", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("ar_reg_en",  32'(reg_en),  0);
        check("ar_busy",    32'(busy),    0);
        check("ar_req_rdy", 32'(req_rdy), 0);
        req_en = 3'b100;
        step();
        check("ar_hold_en", 32'(reg_en), 0);
        rst = 1'b1;
        step();
        check("ar_g2_en",   32'(reg_en),   1);
        check("ar_g2_addr", 32'(reg_addr), 32'h77);
        reg_rdy  = 1'b1;
        reg_dout = 8'h5C;
        step();
        reg_rdy = 1'b0;
        check("ar_g2_rdy",  32'(req_rdy),  32'b100);
        check("ar_g2_dout", 32'(req_dout), 32'h5C);
        req_en = 3'b101;
        step();
        step();
        check("ar_wrap_addr", 32'(reg_addr), 32'h04);
        reg_rdy = 1'b1;
        step();
        reg_rdy = 1'b0;
        check("ar_wrap_rdy", 32'(req_rdy), 32'b001);
        req_en = 3'b000;
        step();
        step();
        check("ar_end_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
